// File: rtl/alu_apb_master.sv
// alu_apb_master
//
// Bridges single read/write commands onto an APB port (the ALU register
// slave). Each accepted command becomes one two-phase APB transfer:
// SETUP for one cycle, then ACCESS until pready. Read data and an error
// flag are returned on a valid/ready response channel. Only one transfer
// is in flight at a time.
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT cycles of pready low (response carries rsp_err=1). Without
// the macro there is no wait counter and ACCESS waits for pready forever.
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write, cmd_addr, cmd_wdata  command payload
//   rsp_valid/rsp_ready             response handshake
//   rsp_rdata, rsp_err              response payload
//   psel, penable, pwrite, paddr, pwdata, prdata, pready   APB master port
//
// State table:
//   S_IDLE   | ready for a command; misaligned address skips APB
//   S_SETUP  | APB setup phase, psel=1 penable=0, exactly one cycle
//   S_ACCESS | APB access phase, psel=1 penable=1, waits for pready
//   S_RESP   | response presented, held until rsp_ready
module alu_apb_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic accept;
    logic misaligned;
    logic timeout_hit;

    assign accept     = (state_q == S_IDLE) && cmd_valid;
    assign misaligned = (cmd_addr[1:0] != 2'b00);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

    logic [WAIT_W-1:0] wait_q;

    // Counts ACCESS cycles with pready low; cleared as the transfer enters
    // SETUP and saturated so it can never wrap back under the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q <= '0;
        end else if (accept && !misaligned) begin
            wait_q <= '0;
        end else if ((state_q == S_ACCESS) && !pready && (wait_q != WAIT_MAX)) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    // The TIMEOUT-th low-pready ACCESS cycle aborts; pready on that same
    // cycle still completes normally because !pready gates the abort.
    assign timeout_hit = (state_q == S_ACCESS) && !pready && (wait_q == WAIT_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = misaligned ? S_RESP : S_SETUP;
                end
            end
            S_SETUP: begin
                psel    = 1'b1;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready || timeout_hit) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Command fields are latched only on acceptance so the APB address and
    // data stay put through IDLE and RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            wr_q    <= cmd_write;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            if (misaligned) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end else if ((state_q == S_ACCESS) && pready) begin
            rdata_q <= wr_q ? '0 : prdata;
            err_q   <= 1'b0;
        end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
        end
    end

    assign pwrite    = wr_q;
    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_apb_master.sv
module tb_alu_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    rsp_t exp_q[$];

    always #5 clk = ~clk;

    alu_apb_master #(
        .ADDR_W(AW),
        .DATA_W(DW)
`ifdef APB_MASTER_TIMEOUT_EN
        ,
        .TIMEOUT(TO)
`endif
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready)
    );

    // One command from acceptance to response handshake. Called at a negedge.
    // wait_n: ACCESS cycles with pready low before the slave answers.
    // hold: cycles of rsp_ready backpressure, with a pending command held
    //       on cmd_valid (write 0x20 <- 0x12345678) during that time.
    task automatic do_cmd(input string name, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int wait_n,
                          input logic [DW-1:0] rd, input int hold);
        logic mis;
        logic to;
        int   exp_acc;
        int   exp_lat;
        int   exp_psel;
        rsp_t e;
        rsp_t got;
        rsp_t want;
        int   psel_n = 0;
        int   pen_n = 0;
        int   acc = 0;
        int   lat = 0;
        int   perr = 0;
        int   busy_err = 0;
        int   stab_err = 0;
        bit   seen = 0;
        logic prev_psel = 1'b0;

        mis = (addr[1:0] != 2'b00);
        to  = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        to  = !mis && (wait_n >= TO);
`endif
        exp_acc  = mis ? 0 : (to ? TO : wait_n + 1);
        exp_lat  = mis ? 1 : 2 + exp_acc;
        exp_psel = mis ? 0 : 1 + exp_acc;
        e.rdata  = (mis || to || wr) ? '0 : rd;
        e.err    = mis || to;

        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        n_checks++;
        if (cmd_ready !== 1'b1)
            $display("FAIL %s accept_ready got %b exp 1", name, cmd_ready);
        else
            n_pass++;
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (rsp_valid === 1'b1) begin
                seen = 1;
            end else begin
                if (cmd_ready !== 1'b0) busy_err++;
                if (penable && (!psel || !prev_psel)) perr++;
                if (psel) begin
                    psel_n++;
                    if (paddr !== addr || pwrite !== wr || pwdata !== wdata) perr++;
                end
                if (penable) begin
                    pen_n++;
                    acc++;
                end
                pready = penable && (acc > wait_n);
                prdata = rd;
                prev_psel = psel;
                @(negedge clk);
                lat++;
            end
        end
        pready = 1'b0;

        n_checks++;
        if (!seen) begin
            $display("FAIL %s rsp_timeout got no rsp_valid exp rsp_valid", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end else begin
            n_pass++;
        end

        n_checks++;
        if (lat !== exp_lat) $display("FAIL %s latency got %0d exp %0d", name, lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (psel_n !== exp_psel) $display("FAIL %s psel_cycles got %0d exp %0d", name, psel_n, exp_psel);
        else n_pass++;
        n_checks++;
        if (pen_n !== exp_acc) $display("FAIL %s penable_cycles got %0d exp %0d", name, pen_n, exp_acc);
        else n_pass++;
        n_checks++;
        if (perr !== 0 || busy_err !== 0)
            $display("FAIL %s apb_protocol got %0d/%0d errors exp 0/0", name, perr, busy_err);
        else n_pass++;
        n_checks++;
        if (psel !== 1'b0 || penable !== 1'b0)
            $display("FAIL %s resp_apb_idle got psel=%b penable=%b exp 0/0", name, psel, penable);
        else n_pass++;

        got.rdata = rsp_rdata;
        got.err   = rsp_err;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s scoreboard got response exp none queued", name);
        end else begin
            want = exp_q.pop_front();
            if (got !== want)
                $display("FAIL %s response got rdata=%h err=%b exp rdata=%h err=%b",
                         name, got.rdata, got.err, want.rdata, want.err);
            else
                n_pass++;
        end

        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 32'h20;
            cmd_wdata = 32'h1234_5678;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== got.rdata || rsp_err !== got.err
                || cmd_ready !== 1'b0 || psel !== 1'b0)
                stab_err++;
        end
        if (hold > 0) begin
            n_checks++;
            if (stab_err !== 0) $display("FAIL %s backpressure_stable got %0d errors exp 0", name, stab_err);
            else n_pass++;
        end

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL %s after_handshake got cmd_ready=%b rsp_valid=%b exp 1/0",
                     name, cmd_ready, rsp_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err} !== 6'b100000)
            $display("FAIL reset_ctrl got %b exp 100000",
                     {cmd_ready, psel, penable, pwrite, rsp_valid, rsp_err});
        else n_pass++;
        n_checks++;
        if (paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0)
            $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h exp 0/0/0", paddr, pwdata, rsp_rdata);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        do_cmd("write_0x10", 1'b1, 32'h10, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_read_wait();
        do_cmd("read_0x14_wait3", 1'b0, 32'h14, 32'h0, 3, 32'h5, 0);
    endtask

    task automatic test_misaligned();
        do_cmd("misaligned_rd_0x13", 1'b0, 32'h13, 32'h0, 0, 32'h77, 0);
        do_cmd("misaligned_wr_0x11", 1'b1, 32'h11, 32'hAAAA_5555, 0, 32'h77, 0);
    endtask

    task automatic test_mixed();
        for (int i = 0; i < 6; i++) begin
            logic          wr;
            logic [AW-1:0] a;
            wr = 1'($urandom_range(0, 1));
            a  = $urandom & 32'h0000_0FFC;
            if (i == 3) a = a | 32'h2;
            do_cmd("mixed", wr, a, $urandom, int'($urandom_range(0, 4)), $urandom, 0);
        end
    endtask

    task automatic test_timeout();
`ifdef APB_MASTER_TIMEOUT_EN
        do_cmd("timeout_0x18", 1'b0, 32'h18, 32'h0, 1000, 32'hA5, 0);
        do_cmd("limit_ready_0x18", 1'b0, 32'h18, 32'h0, TO - 1, 32'hA5, 0);
`else
        do_cmd("long_wait_0x18", 1'b0, 32'h18, 32'h0, TO + 4, 32'hA5, 0);
`endif
    endtask

    task automatic test_back_to_back();
        do_cmd("backpressure_rd", 1'b0, 32'h24, 32'h0, 1, 32'hCAFE_0001, 5);
        do_cmd("next_after_hs", 1'b1, 32'h20, 32'h1234_5678, 0, 32'h0, 0);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h1C;
        cmd_wdata = 32'h0;
        pready    = 1'b0;
        prdata    = 32'h99;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (psel !== 1'b1 || penable !== 1'b1)
            $display("FAIL reset_mid_in_access got psel=%b penable=%b exp 1/1", psel, penable);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1)
            $display("FAIL reset_mid_async got psel=%b penable=%b rsp_valid=%b cmd_ready=%b exp 0/0/0/1",
                     psel, penable, rsp_valid, cmd_ready);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        pready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || psel !== 1'b0 || cmd_ready !== 1'b1) bad++;
        end
        pready = 1'b0;
        n_checks++;
        if (bad !== 0) $display("FAIL reset_mid_no_stale got %0d bad cycles exp 0", bad);
        else n_pass++;
        do_cmd("after_reset_rd", 1'b0, 32'h28, 32'h0, 2, 32'h0BAD_F00D, 0);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_misaligned();
        test_mixed();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
